psum_add_arb: RTL and testbench

- Shares one saturating psum adder (existing module adder_fixed, signed fixed point (12,5)) among NUM_REQ requesters, such as PE-row psum merge ports.
- Arbitrates round-robin and accepts at most one add per cycle.
- Registers the result together with the winner's ID and a saturation flag.
- Tracks a running saturation-event count for debug and quantisation tuning.

---
 rtl/psum_add_arb_pkg.sv | 17 +
 rtl/adder_fixed.sv | 21 ++
 rtl/psum_add_arb_rr_arbiter.sv | 30 +++
 rtl/psum_add_arb.sv | 127 ++++++++++++
 tb/tb_psum_add_arb.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/psum_add_arb_pkg.sv
// Shared psum definitions: fixed-point (12,5) width, clamp limits, overflow helper.
package psum_add_arb_pkg;

   localparam int unsigned PSUM_DATA_SIZE = 12;
   localparam logic [PSUM_DATA_SIZE-1:0] PSUM_MAX = 12'h7FF;
   localparam logic [PSUM_DATA_SIZE-1:0] PSUM_MIN = 12'h800;

   typedef logic signed [PSUM_DATA_SIZE-1:0] psum_t;

   // True when the exact sign-extended sum does not fit in PSUM_DATA_SIZE bits.
   function automatic logic psum_ovf(input psum_t a, input psum_t b);
      logic [PSUM_DATA_SIZE:0] ext;
      ext = {a[PSUM_DATA_SIZE-1], a} + {b[PSUM_DATA_SIZE-1], b};
      return ext[PSUM_DATA_SIZE] ^ ext[PSUM_DATA_SIZE-1];
   endfunction

endpackage

// File: rtl/adder_fixed.sv
// Saturating signed fixed-point (12,5) adder; clamps to PSUM_MAX / PSUM_MIN.
module adder_fixed
   import psum_add_arb_pkg::*;
(
   input  psum_t a,
   input  psum_t b,
   output psum_t sum
);

   logic [PSUM_DATA_SIZE:0] ext;

   // Exact 13-bit sum, then clamp on overflow toward the operand sign.
   always_comb begin
      ext = {a[PSUM_DATA_SIZE-1], a} + {b[PSUM_DATA_SIZE-1], b};
      if (ext[PSUM_DATA_SIZE] ^ ext[PSUM_DATA_SIZE-1])
         sum = ext[PSUM_DATA_SIZE] ? PSUM_MIN : PSUM_MAX;
      else
         sum = ext[PSUM_DATA_SIZE-1:0];
   end

endmodule

// File: rtl/psum_add_arb_rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or after ptr wins.
module rr_arbiter
   import psum_add_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    win,
   output logic               any_valid
);

   // Cyclic scan starting at ptr; the first hit is the winner.
   always_comb begin
      win       = '0;
      any_valid = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         int unsigned idx;
         idx = (int'(ptr) + i) % NUM_REQ;
         if (!any_valid && req[ID_W'(idx)]) begin
            any_valid = 1'b1;
            win       = ID_W'(idx);
         end
      end
      grant = any_valid ? (NUM_REQ'(1) << win) : '0;
   end

endmodule

// File: rtl/psum_add_arb.sv
// Shared saturating psum adder with round-robin arbitration and a registered
// result (sum, winner id, saturation flag) plus a saturation-event counter.
module psum_add_arb
   import psum_add_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned ID_W      = $clog2(NUM_REQ),
   parameter int unsigned SAT_CNT_W = 16
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [NUM_REQ-1:0]                  req_valid,
   output logic [NUM_REQ-1:0]                  req_ready,
   input  logic [NUM_REQ*PSUM_DATA_SIZE-1:0]   req_a,
   input  logic [NUM_REQ*PSUM_DATA_SIZE-1:0]   req_b,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [PSUM_DATA_SIZE-1:0]           out_sum,
   output logic [ID_W-1:0]                     out_id,
   output logic                                out_sat,
   output logic [SAT_CNT_W-1:0]                sat_cnt,
   input  logic                                sat_clr
);

   logic [ID_W-1:0]           rr_ptr_q, rr_ptr_d;
   logic                      out_valid_q, out_valid_d;
   logic [PSUM_DATA_SIZE-1:0] out_sum_q, out_sum_d;
   logic [ID_W-1:0]           out_id_q, out_id_d;
   logic                      out_sat_q, out_sat_d;
   logic [SAT_CNT_W-1:0]      sat_cnt_q, sat_cnt_d;

   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    win;
   logic               any_valid;
   logic               can_accept;
   logic               accept;
   psum_t              a_sel, b_sel, sum_sat;
   logic               sat;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr_q),
      .grant     (grant),
      .win       (win),
      .any_valid (any_valid)
   );

   // Handshake: accept only when the output slot is free or draining; no
   // ready is advertised while reset is asserted.
   always_comb begin
      can_accept = ~out_valid_q | out_ready;
      accept     = any_valid & can_accept & rst_n;
      req_ready  = grant & {NUM_REQ{can_accept & rst_n}};
   end

   // Operand mux: route the winner's A/B into the single shared adder.
   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (ID_W'(i) == win) begin
            a_sel = req_a[i*PSUM_DATA_SIZE +: PSUM_DATA_SIZE];
            b_sel = req_b[i*PSUM_DATA_SIZE +: PSUM_DATA_SIZE];
         end
      end
      sat = psum_ovf(a_sel, b_sel);
   end

   adder_fixed u_add (
      .a   (a_sel),
      .b   (b_sel),
      .sum (sum_sat)
   );

   // Next-state: result load on accept, drain when downstream takes it,
   // pointer advance past the winner, clear-dominant saturating counter.
   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_id_d    = out_id_q;
      out_sat_d   = out_sat_q;
      sat_cnt_d   = sat_cnt_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_sum_d   = sum_sat;
         out_id_d    = win;
         out_sat_d   = sat;
         rr_ptr_d    = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
      if (sat_clr)
         sat_cnt_d = '0;
      else if (accept && sat && (sat_cnt_q != '1))
         sat_cnt_d = sat_cnt_q + 1'b1;
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_id_q    <= '0;
         out_sat_q   <= 1'b0;
         sat_cnt_q   <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_id_q    <= out_id_d;
         out_sat_q   <= out_sat_d;
         sat_cnt_q   <= sat_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_id    = out_id_q;
   assign out_sat   = out_sat_q;
   assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_psum_add_arb.sv
// Directed bench for psum_add_arb with a reference arbiter/adder model and a
// result scoreboard; a second instance with a 2-bit counter exercises the
// counter saturation boundary.
module tb_psum_add_arb;

   localparam int N = 4;
   localparam int W = 12;

   typedef struct {
      logic [11:0] sum;
      logic [1:0]  id;
      logic        sat;
   } res_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_ready, req_ready2;
   logic [N*W-1:0] req_a, req_b;
   logic          out_valid, out_valid2;
   logic          out_ready;
   logic [W-1:0]  out_sum, out_sum2;
   logic [1:0]    out_id, out_id2;
   logic          out_sat, out_sat2;
   logic [15:0]   sat_cnt;
   logic [1:0]    sat_cnt2;
   logic          sat_clr;

   int checks   = 0;
   int failures = 0;

   // reference model state
   res_t        sb[$];
   int          m_ptr;
   logic        m_ov;
   logic [11:0] m_sum;
   logic [1:0]  m_id;
   logic        m_sat;
   int          m_cnt, m_cnt2;
   bit          hold_valid;

   always #5 clk = ~clk;

   psum_add_arb #(.NUM_REQ(4), .SAT_CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_id(out_id), .out_sat(out_sat),
      .sat_cnt(sat_cnt), .sat_clr(sat_clr)
   );

   psum_add_arb #(.NUM_REQ(4), .SAT_CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready2),
      .req_a(req_a), .req_b(req_b), .out_valid(out_valid2), .out_ready(out_ready),
      .out_sum(out_sum2), .out_id(out_id2), .out_sat(out_sat2),
      .sat_cnt(sat_cnt2), .sat_clr(sat_clr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [11:0] a, input logic [11:0] b);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
      req_valid[i]    = 1'b1;
   endtask

   task automatic model_reset();
      sb.delete();
      m_ptr = 0; m_ov = 1'b0; m_sum = '0; m_id = '0; m_sat = 1'b0;
      m_cnt = 0; m_cnt2 = 0;
   endtask

   function automatic res_t ref_add(input logic [11:0] a, input logic [11:0] b, input int id);
      res_t r;
      int   s;
      s = int'($signed(a)) + int'($signed(b));
      r.id = 2'(id);
      if (s > 2047)       begin r.sum = 12'h7FF; r.sat = 1'b1; end
      else if (s < -2048) begin r.sum = 12'h800; r.sat = 1'b1; end
      else                begin r.sum = 12'(s);  r.sat = 1'b0; end
      return r;
   endfunction

   task automatic check_outputs(input string tag);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
      chk({tag, ".out_sum"},   32'(out_sum),   32'(m_sum));
      chk({tag, ".out_id"},    32'(out_id),    32'(m_id));
      chk({tag, ".out_sat"},   32'(out_sat),   32'(m_sat));
      chk({tag, ".sat_cnt"},   32'(sat_cnt),   32'(m_cnt));
      chk({tag, ".sat_cnt2"},  32'(sat_cnt2),  32'(m_cnt2));
      chk({tag, ".out_sum2"},  32'(out_sum2),  32'(m_sum));
   endtask

   // One cycle: predict grant, check ready, predict the register update, check it.
   task automatic step(input string tag);
      bit          can, found, acc, s;
      int          w;
      logic [3:0]  exp_ready;
      res_t        r;
      #2;
      can = !m_ov || out_ready;
      found = 1'b0; w = 0;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (m_ptr + k) % N;
         if (!found && req_valid[idx]) begin found = 1'b1; w = idx; end
      end
      acc = found && can;
      exp_ready = acc ? 4'(1 << w) : 4'b0000;
      chk({tag, ".req_ready"},  32'(req_ready),  32'(exp_ready));
      chk({tag, ".req_ready2"}, 32'(req_ready2), 32'(exp_ready));
      s = 1'b0;
      if (acc) begin
         r = ref_add(req_a[w*W +: W], req_b[w*W +: W], w);
         s = r.sat;
         sb.push_back(r);
         m_ptr = (w + 1) % N;
      end
      if (sat_clr) begin
         m_cnt = 0; m_cnt2 = 0;
      end else if (acc && s) begin
         if (m_cnt  < 65535) m_cnt++;
         if (m_cnt2 < 3)     m_cnt2++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
         if (sb.size() == 0) begin
            checks++; failures++;
            $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
         end else begin
            r = sb.pop_front();
            m_sum = r.sum; m_id = r.id; m_sat = r.sat; m_ov = 1'b1;
         end
         if (!hold_valid) req_valid[w] = 1'b0;
      end else if (out_ready) begin
         m_ov = 1'b0;
      end
      check_outputs(tag);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = '1; req_a = '0; req_b = '0;
      out_ready = 1'b1; sat_clr = 1'b0; hold_valid = 1'b0;
      model_reset();

      // reset state, ready suppressed while in reset
      #12;
      chk("rst.req_ready", 32'(req_ready), 32'h0);
      check_outputs("rst");
      @(posedge clk); #1;
      req_valid = '0; rst_n = 1'b1;

      // single request on requester 1
      set_req(1, 12'h010, 12'h020);
      step("single");
      chk("single.sum_const", 32'(out_sum), 32'h030);
      chk("single.id_const",  32'(out_id),  32'h1);
      step("drain");

      // fresh reset, then all four valid continuously: 0,1,2,3,0,1
      rst_n = 1'b0; #1; model_reset(); @(posedge clk); #1; rst_n = 1'b1;
      hold_valid = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, 12'(i * 16), 12'(i));
      for (int k = 0; k < 6; k++) begin
         step("rr");
         chk("rr.order", 32'(out_id), 32'(k % N));
      end
      hold_valid = 1'b0;
      req_valid = '0;
      step("idle");

      // saturation cases
      set_req(0, 12'h7F0, 12'h020); step("satpos");
      set_req(0, 12'h800, 12'hFFF); step("satneg");
      set_req(0, 12'h400, 12'h3FF); step("edgemax");
      set_req(0, 12'hC00, 12'hC00); step("edgemin");

      // stall: pending result, out_ready low, requesters 2/3 waiting
      set_req(0, 12'h001, 12'h002); step("preload");
      out_ready = 1'b0;
      set_req(2, 12'h100, 12'h001);
      set_req(3, 12'h200, 12'h002);
      for (int k = 0; k < 3; k++) step("stall");
      out_ready = 1'b1;
      step("unstall");
      chk("unstall.id2", 32'(out_id), 32'h2);
      step("take3");

      // counter saturation on the narrow instance, then clear vs increment
      set_req(1, 12'h7FF, 12'h7FF); step("cnt_a");
      set_req(1, 12'h800, 12'h800); step("cnt_b");
      set_req(1, 12'h700, 12'h200); step("cnt_c");
      sat_clr = 1'b1;
      set_req(1, 12'h7FF, 12'h001); step("clr_inc");
      sat_clr = 1'b0;
      step("drain2");

      // reset mid-operation with a pending result and pointer at 3
      set_req(2, 12'h055, 12'h011); step("pre_rst");
      chk("pre_rst.valid", 32'(out_valid), 32'h1);
      req_valid = 4'b1001;
      rst_n = 1'b0; #1;
      model_reset();
      chk("midrst.out_valid", 32'(out_valid), 32'h0);
      chk("midrst.sat_cnt",   32'(sat_cnt),   32'h0);
      chk("midrst.req_ready", 32'(req_ready), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      set_req(0, 12'h003, 12'h004);
      set_req(3, 12'h005, 12'h006);
      step("post_rst");
      chk("post_rst.id0", 32'(out_id), 32'h0);
      step("post_rst3");
      step("end_drain");

      chk("scoreboard_empty", 32'(sb.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
